// File: rtl/uart_multi_byte_tx_if.sv
// Packet handshake and serial line of uart_multi_byte_tx.
// master: user logic issuing packets; slave: the transmitter itself.
interface uart_multi_byte_tx_if #(
  parameter int unsigned BYTE_NUM = 4
);
  logic                  tx_start;
  logic [BYTE_NUM*8-1:0] tx_data;
  logic                  tx_busy;
  logic                  tx_done;
  logic                  uart_txd;

  modport master (
    output tx_start,
    output tx_data,
    input  tx_busy,
    input  tx_done,
    input  uart_txd
  );

  modport slave (
    input  tx_start,
    input  tx_data,
    output tx_busy,
    output tx_done,
    output uart_txd
  );
endinterface

// File: rtl/uart_multi_byte_tx.sv
// Multi-byte UART transmitter: a BYTE_NUM-byte packet goes out as back-to-back frames, byte 0 first.
// Define UART_TX_PARITY_EN for 8E1 frames; the default build sends 8N1.
module uart_multi_byte_tx #(
  parameter int unsigned BPS      = 9_600,
  parameter int unsigned CLK_FRE  = 50_000_000,
  parameter int unsigned BYTE_NUM = 4
) (
  input logic                 sys_clk,
  input logic                 sys_rst_n,
  uart_multi_byte_tx_if.slave tx_if
);

  localparam int unsigned BpsCnt  = CLK_FRE / BPS;
  localparam int unsigned DataW   = BYTE_NUM * 8;
  localparam int unsigned ByteW   = (BYTE_NUM > 1) ? $clog2(BYTE_NUM) : 1;
  localparam logic [31:0] BitLast = 32'(BpsCnt - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_TX_PARITY_EN
    StParity,
`endif
    StStop
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        clk_cnt_q, clk_cnt_d;
  logic [2:0]         bit_cnt_q, bit_cnt_d;
  logic [ByteW-1:0]   byte_cnt_q, byte_cnt_d;
  logic [DataW-1:0]   shift_q, shift_d;
  logic               txd_q, txd_d;
  logic               busy_q;
  logic               done_q;
  logic               bit_end;
  logic [7:0]         cur_byte;

  assign bit_end  = (clk_cnt_q == BitLast);
  // The byte on the wire is always the low byte; the packet shifts down between frames.
  assign cur_byte = shift_q[7:0];

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    clk_cnt_d  = (state_q == StIdle || bit_end) ? '0 : clk_cnt_q + 32'd1;

    unique case (state_q)
      StIdle: begin
        if (tx_if.tx_start) begin
          shift_d    = tx_if.tx_data;
          byte_cnt_d = '0;
          bit_cnt_d  = '0;
          state_d    = StStart;
        end
      end
      StStart: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          state_d   = StData;
        end
      end
      StData: begin
        if (bit_end) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (bit_end) state_d = StStop;
      end
`endif
      StStop: begin
        if (bit_end) begin
          if (32'(byte_cnt_q) < BYTE_NUM - 1) begin
            byte_cnt_d = byte_cnt_q + ByteW'(1);
            shift_d    = shift_q >> 8;
            state_d    = StStart;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Line level follows the state one cycle later, keeping uart_txd a clean flop output.
  always_comb begin
    txd_d = 1'b1;
    unique case (state_q)
      StStart:  txd_d = 1'b0;
      StData:   txd_d = cur_byte[bit_cnt_q];
`ifdef UART_TX_PARITY_EN
      StParity: txd_d = ^cur_byte;
`endif
      default:  txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= StIdle;
      clk_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      txd_q      <= txd_d;
      busy_q     <= (state_q != StIdle);
      // Busy falling marks the end of the last stop bit on the line.
      done_q     <= busy_q && (state_q == StIdle);
    end
  end

  assign tx_if.uart_txd = txd_q;
  assign tx_if.tx_busy  = busy_q;
  assign tx_if.tx_done  = done_q;

  done_not_busy_a : assert property (@(posedge sys_clk) disable iff (!sys_rst_n)
    done_q |-> !busy_q);
  done_single_a : assert property (@(posedge sys_clk) disable iff (!sys_rst_n)
    done_q |=> !done_q);

endmodule

// File: tb/tb_uart_multi_byte_tx.sv
// Directed self-checking bench for uart_multi_byte_tx with a short bit period (100/6 -> 16 cycles).
module tb_uart_multi_byte_tx;

  localparam int unsigned Bps     = 6;
  localparam int unsigned ClkFre  = 100;
  localparam int unsigned ByteNum = 4;
  localparam int unsigned BpsCnt  = 16;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned FrameBits = 11;
`else
  localparam int unsigned FrameBits = 10;
`endif
  localparam int unsigned Frame    = FrameBits * BpsCnt;
  localparam int unsigned Packet   = ByteNum * Frame;
  localparam int unsigned RxWait   = 3 * Frame;
  localparam int unsigned DoneWait = Packet + 4 * Frame;

  logic        sys_clk;
  logic        sys_rst_n;
  int unsigned cyc = 0;
  int unsigned done_count = 0;
  int          checks = 0;
  int          failures = 0;

  uart_multi_byte_tx_if #(.BYTE_NUM(ByteNum)) tx_if ();

  uart_multi_byte_tx #(
    .BPS      (Bps),
    .CLK_FRE  (ClkFre),
    .BYTE_NUM (ByteNum)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .tx_if     (tx_if)
  );

  wire uart_txd = tx_if.uart_txd;
  wire tx_busy  = tx_if.tx_busy;
  wire tx_done  = tx_if.tx_done;

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;
  always @(negedge sys_clk) if (tx_done === 1'b1) done_count <= done_count + 1;

  // Called at a negedge; returns at the negedge after the accepting edge with acc = that edge.
  task automatic pulse_start(input logic [31:0] d, output int unsigned acc);
    tx_if.tx_start = 1'b1;
    tx_if.tx_data  = d;
    @(negedge sys_clk);
    acc = cyc;
    tx_if.tx_start = 1'b0;
    tx_if.tx_data  = ~d;
  endtask

  // Mid-bit sampling receiver; ok means start bit low and stop bit high at their centres.
  task automatic rx_byte(output logic [7:0] b, output logic par, output bit ok);
    int n = 0;
    b = '0;
    par = 1'b0;
    ok = 1'b0;
    while (uart_txd !== 1'b0 && n < RxWait) begin
      @(negedge sys_clk);
      n++;
    end
    if (uart_txd !== 1'b0) return;
    repeat (BpsCnt / 2) @(negedge sys_clk);
    ok = (uart_txd === 1'b0);
    for (int i = 0; i < 8; i++) begin
      repeat (BpsCnt) @(negedge sys_clk);
      b[i] = uart_txd;
    end
`ifdef UART_TX_PARITY_EN
    repeat (BpsCnt) @(negedge sys_clk);
    par = uart_txd;
`endif
    repeat (BpsCnt) @(negedge sys_clk);
    ok = ok && (uart_txd === 1'b1);
  endtask

  task automatic wait_done(output int unsigned at, output bit seen);
    int n = 0;
    while (tx_done !== 1'b1 && n < DoneWait) begin
      @(negedge sys_clk);
      n++;
    end
    seen = (tx_done === 1'b1);
    at = cyc;
  endtask

  task automatic watch_idle(input int unsigned len, output int bad);
    bad = 0;
    repeat (len) begin
      @(negedge sys_clk);
      if (uart_txd !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) bad++;
    end
  endtask

  task automatic test_reset();
    int bad;
    sys_rst_n = 1'b0;
    tx_if.tx_start = 1'b0;
    tx_if.tx_data = '0;
    repeat (3) @(negedge sys_clk);
    checks++;
    if (uart_txd !== 1'b1) begin
      failures++;
      $display("FAIL reset_txd: got %b expected 1", uart_txd);
    end
    checks++;
    if (tx_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy: got %b expected 0", tx_busy);
    end
    checks++;
    if (tx_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_done: got %b expected 0", tx_done);
    end
    sys_rst_n = 1'b1;
    watch_idle(10 * Frame, bad);
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL reset_idle_line: got %0d non-idle samples expected 0", bad);
    end
  endtask

  task automatic test_single();
    int unsigned n, d;
    logic [7:0] b;
    logic p;
    bit ok, seen;
    logic [7:0] exp_b [4];
    exp_b = '{8'h81, 8'h0F, 8'hAA, 8'h55};
    pulse_start(32'h55AA_0F81, n);
    checks++;
    if (uart_txd !== 1'b1) begin
      failures++;
      $display("FAIL single_txd_at_accept: got %b expected 1", uart_txd);
    end
    @(negedge sys_clk);
    checks++;
    if (uart_txd !== 1'b0 || tx_busy !== 1'b1) begin
      failures++;
      $display("FAIL single_start_edge: got txd=%b busy=%b expected txd=0 busy=1",
               uart_txd, tx_busy);
    end
    for (int k = 0; k < 4; k++) begin
      rx_byte(b, p, ok);
      checks++;
      if (!ok || b !== exp_b[k]) begin
        failures++;
        $display("FAIL single_byte%0d: got %h framing_ok=%0d expected %h", k, b, ok, exp_b[k]);
      end
    end
    wait_done(d, seen);
    checks++;
    if (!seen || d !== n + 1 + Packet) begin
      failures++;
      $display("FAIL single_done_time: got edge %0d (seen=%0d) expected %0d", d, seen,
               n + 1 + Packet);
    end
    checks++;
    if (tx_busy !== 1'b0) begin
      failures++;
      $display("FAIL single_busy_at_done: got %b expected 0", tx_busy);
    end
    @(negedge sys_clk);
    checks++;
    if (tx_done !== 1'b0) begin
      failures++;
      $display("FAIL single_done_width: got %b expected 0", tx_done);
    end
  endtask

  task automatic test_bit_timing();
    int unsigned n, d;
    int first_len = 0, second_len = 0, idx = 0, len, bad = 0;
    logic lvl, first_lvl;
    bit seen;
    repeat (5) @(negedge sys_clk);
    pulse_start(32'h55AA_0F81, n);
    @(negedge sys_clk);
    lvl = uart_txd;
    first_lvl = lvl;
    len = 1;
    for (int i = 1; i < int'(Packet); i++) begin
      @(negedge sys_clk);
      if (uart_txd === lvl) begin
        len++;
      end else begin
        if (idx == 0) first_len = len;
        else if (idx == 1) second_len = len;
        if (len % BpsCnt != 0) bad++;
        idx++;
        lvl = uart_txd;
        len = 1;
      end
    end
    if (len % BpsCnt != 0) bad++;
    checks++;
    if (first_lvl !== 1'b0 || first_len != 16) begin
      failures++;
      $display("FAIL bt_start_run: got level %b for %0d cycles expected 0 for 16",
               first_lvl, first_len);
    end
    checks++;
    if (second_len != 16) begin
      failures++;
      $display("FAIL bt_bit0_run: got %0d cycles expected 16", second_len);
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL bt_run_multiple: got %0d odd-length runs expected 0", bad);
    end
    wait_done(d, seen);
    checks++;
    if (!seen || d !== n + 1 + Packet) begin
      failures++;
      $display("FAIL bt_done_time: got edge %0d expected %0d", d, n + 1 + Packet);
    end
    @(negedge sys_clk);
  endtask

  task automatic test_busy_ignore();
    int unsigned n, m, d, base;
    int bad;
    logic [7:0] got [4];
    bit oks [4];
    logic [7:0] exp_b [4];
    logic p;
    bit seen;
    exp_b = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    base = done_count;
    repeat (3) @(negedge sys_clk);
    pulse_start(32'hDEAD_BEEF, n);
    fork
      begin
        for (int k = 0; k < 4; k++) rx_byte(got[k], p, oks[k]);
      end
      begin
        repeat (Frame + Frame / 2) @(negedge sys_clk);
        pulse_start(32'h1234_5678, m);
      end
    join
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (!oks[k] || got[k] !== exp_b[k]) begin
        failures++;
        $display("FAIL busy_byte%0d: got %h framing_ok=%0d expected %h", k, got[k], oks[k],
                 exp_b[k]);
      end
    end
    wait_done(d, seen);
    checks++;
    if (!seen || d !== n + 1 + Packet) begin
      failures++;
      $display("FAIL busy_done_time: got edge %0d expected %0d", d, n + 1 + Packet);
    end
    @(negedge sys_clk);
    watch_idle(2 * Frame, bad);
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL busy_no_second_packet: got %0d non-idle samples expected 0", bad);
    end
    checks++;
    if (done_count - base != 1) begin
      failures++;
      $display("FAIL busy_done_count: got %0d expected 1", done_count - base);
    end
  endtask

  task automatic test_back_to_back();
    int unsigned c0, d1, d2, base;
    logic [7:0] got [8];
    bit oks [8];
    logic [7:0] exp_b [8];
    logic l0, l1, p;
    bit seen1, seen2;
    exp_b = '{8'h04, 8'h03, 8'h02, 8'h01, 8'h04, 8'h03, 8'h02, 8'h01};
    base = done_count;
    l0 = 1'b0;
    l1 = 1'b1;
    d1 = 0;
    seen1 = 1'b0;
    c0 = cyc;
    tx_if.tx_start = 1'b1;
    tx_if.tx_data = 32'h0102_0304;
    fork
      begin
        for (int k = 0; k < 8; k++) rx_byte(got[k], p, oks[k]);
      end
      begin
        wait_done(d1, seen1);
        l0 = uart_txd;
        @(negedge sys_clk);
        l1 = uart_txd;
        tx_if.tx_start = 1'b0;
      end
    join
    checks++;
    if (!seen1 || d1 !== c0 + 2 + Packet) begin
      failures++;
      $display("FAIL b2b_done1_time: got edge %0d expected %0d", d1, c0 + 2 + Packet);
    end
    checks++;
    if (l0 !== 1'b1 || l1 !== 1'b0) begin
      failures++;
      $display("FAIL b2b_restart: got txd %b then %b expected 1 then 0", l0, l1);
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (!oks[k] || got[k] !== exp_b[k]) begin
        failures++;
        $display("FAIL b2b_byte%0d: got %h framing_ok=%0d expected %h", k, got[k], oks[k],
                 exp_b[k]);
      end
    end
    wait_done(d2, seen2);
    checks++;
    if (!seen2 || d2 !== d1 + 1 + Packet) begin
      failures++;
      $display("FAIL b2b_done2_time: got edge %0d expected %0d", d2, d1 + 1 + Packet);
    end
    repeat (2 * Frame) @(negedge sys_clk);
    checks++;
    if (done_count - base != 2) begin
      failures++;
      $display("FAIL b2b_done_count: got %0d expected 2", done_count - base);
    end
  endtask

  task automatic test_reset_mid();
    int unsigned n, d, base;
    int bad;
    logic [7:0] b;
    logic p;
    bit ok, seen;
    pulse_start(32'h1122_3344, n);
    // Centre of bit 0 of byte 2 (8'h22): line low
    repeat (1 + 2 * Frame + BpsCnt + BpsCnt / 2) @(negedge sys_clk);
    checks++;
    if (uart_txd !== 1'b0 || tx_busy !== 1'b1) begin
      failures++;
      $display("FAIL rmid_before: got txd=%b busy=%b expected txd=0 busy=1", uart_txd, tx_busy);
    end
    base = done_count;
    sys_rst_n = 1'b0;
    #1;
    checks++;
    if (uart_txd !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
      failures++;
      $display("FAIL rmid_immediate: got txd=%b busy=%b done=%b expected 1 0 0",
               uart_txd, tx_busy, tx_done);
    end
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    watch_idle(3 * Frame, bad);
    checks++;
    if (bad != 0 || done_count != base) begin
      failures++;
      $display("FAIL rmid_abandoned: got %0d non-idle samples, %0d done pulses expected 0 0",
               bad, done_count - base);
    end
    pulse_start(32'hA5A5_A5A5, n);
    for (int k = 0; k < 4; k++) begin
      rx_byte(b, p, ok);
      checks++;
      if (!ok || b !== 8'hA5) begin
        failures++;
        $display("FAIL rmid_byte%0d: got %h framing_ok=%0d expected a5", k, b, ok);
      end
    end
    wait_done(d, seen);
    checks++;
    if (!seen || d !== n + 1 + Packet) begin
      failures++;
      $display("FAIL rmid_done_time: got edge %0d expected %0d", d, n + 1 + Packet);
    end
    @(negedge sys_clk);
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    int unsigned n, d;
    logic [7:0] b0, b1;
    logic p0, p1;
    bit ok0, ok1, seen;
    repeat (3) @(negedge sys_clk);
    pulse_start(32'h0000_0307, n);
    rx_byte(b0, p0, ok0);
    rx_byte(b1, p1, ok1);
    checks++;
    if (!ok0 || b0 !== 8'h07 || p0 !== 1'b1) begin
      failures++;
      $display("FAIL parity_07: got %h parity %b expected 07 parity 1", b0, p0);
    end
    checks++;
    if (!ok1 || b1 !== 8'h03 || p1 !== 1'b0) begin
      failures++;
      $display("FAIL parity_03: got %h parity %b expected 03 parity 0", b1, p1);
    end
    wait_done(d, seen);
    checks++;
    if (!seen || d !== n + 1 + 4 * 11 * BpsCnt) begin
      failures++;
      $display("FAIL parity_done_time: got edge %0d expected %0d", d, n + 1 + 4 * 11 * BpsCnt);
    end
    @(negedge sys_clk);
  endtask
`endif

  initial begin
    #(400_000 * 10);
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_bit_timing();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_multi_byte_tx.md
# uart_multi_byte_tx

Multi-byte UART transmitter: accepts a BYTE_NUM-byte word on a single-cycle start pulse and serialises it onto one TX line as back-to-back 8N1 frames, lowest byte first. Sits between user logic and the board UART pin. It is the transmit counterpart of the team's UART byte-receiver path. Bit timing is derived by integer division of the system clock by the baud rate.

## Interface
- BPS, 9_600, baud rate in bits/s
- CLK_FRE, 50_000_000, sys_clk frequency in Hz
- BYTE_NUM, 4, bytes per packet (≥1)
- sys_clk  input  1  system clock, all logic on rising edge
- sys_rst_n  input  1  asynchronous, active-low reset
- tx_start  input  1  start request; sampled every cycle, acted on only when tx_busy=0
- tx_data  input  BYTE_NUM*8  packet; byte k = tx_data[8k+7:8k]; captured on accepted tx_start
- tx_busy  output  1  high while a packet is in flight
- tx_done  output  1  one-cycle pulse when the last stop bit of the packet has completed
- uart_txd  output  1  serial line, idle high, registered

## Operation
- BPS_CNT = CLK_FRE / BPS (integer truncation); clock counter is 32 bits and wraps at BPS_CNT-1.
- States: IDLE, START, DATA, PARITY (only with the macro), STOP.
- IDLE: uart_txd=1, tx_busy=0. If tx_start=1, latch tx_data into a shift register, clear the byte counter, and enter START.
- START: uart_txd=0 for BPS_CNT cycles, then go to DATA with bit counter 0.
- DATA: drive bit[i] of the current byte, LSB first, each for BPS_CNT cycles. After bit 7, go to PARITY if compiled in, else STOP.
- STOP: uart_txd=1 for BPS_CNT cycles. At the end of STOP:
  - if byte counter < BYTE_NUM-1: increment it and go to START. No idle gap between frames.
  - else: go to IDLE and pulse tx_done.
- tx_start while tx_busy=1 is ignored. It is neither queued nor able to corrupt the captured data.
- Changes on tx_data after capture have no effect on the packet in flight.
- Reset mid-packet: all state returns to its reset values at once and the line goes high. The partial frame is abandoned and no tx_done is produced.
- Reset values: uart_txd=1, tx_busy=0, tx_done=0, state=IDLE, all counters 0, shift register 0.

## Timing
- tx_start accepted at edge N means:
  - uart_txd falls and tx_busy rises at edge N+1;
  - each line bit lasts exactly BPS_CNT cycles.
- Frame length F = 10*BPS_CNT cycles (11*BPS_CNT with parity).
- tx_done=1 and tx_busy=0 both occur at edge N+1+BYTE_NUM*F. tx_done lasts exactly one cycle.
- A tx_start present in the cycle tx_busy is already low is accepted. This allows back-to-back packets with zero idle cycles: the first start bit begins one cycle after tx_done.
- tx_busy=1 continuously from the first start bit through the last stop bit.

## Configuration
- Macro UART_TX_PARITY_EN.
- Defined: an even-parity bit (XOR of the 8 data bits) is inserted between bit 7 and the stop bit, lasting BPS_CNT cycles. The frame becomes 8E1, F = 11*BPS_CNT.
- Undefined: the PARITY state and its logic are absent. Frames are 8N1, F = 10*BPS_CNT.

## Test plan
- Reset: hold sys_rst_n=0 → uart_txd=1, tx_busy=0, tx_done=0. After release with no tx_start, the line stays high for 10 frames.
- Single packet, CLK_FRE=50_000_000, BPS=9600 (BPS_CNT=5208), BYTE_NUM=4, tx_data=32'h55AA_0F81:
  - bench receiver reports 8'h81, 8'h0F, 8'hAA, 8'h55 in that order;
  - tx_done pulses once at 1+4*52080 cycles after the accepted tx_start.
- Bit timing: with BPS_CNT=5208, every low/high run on uart_txd measures an exact multiple of 5208 cycles. For byte 8'h81, the start bit plus bit0 of 8'h81 show as a 5208-cycle low followed by a 5208-cycle high.
- Busy ignore: pulse tx_start with 32'hDEAD_BEEF, then pulse tx_start with 32'h1234_5678 midway through byte 1 → only EF, BE, AD, DE are received, with a single tx_done.
- Back-to-back: hold tx_start=1 with data 32'h0102_0304 → start bit of the second packet begins 1 cycle after tx_done, and 8 bytes are received correctly.
- Reset mid-byte: assert sys_rst_n=0 during DATA of byte 2 → uart_txd=1 and tx_busy=0 immediately, with no tx_done. The next packet 32'hA5A5_A5A5 is received correctly.
- With UART_TX_PARITY_EN and byte 8'h07: the parity bit is 1 and the frame is 11*BPS_CNT long. With byte 8'h03 the parity bit is 0.
